// File: rtl/put_dmvector_pkg.sv
// Shared definitions for the dmvector serializer: code constants, code
// lengths, the FSM state type and the pair encoder.
package put_dmvector_pkg;

    localparam int         PAIR_W          = 4;
    localparam logic [1:0] DMV_ILLEGAL     = 2'b10;

    // Variable-length codes, MSB transmitted first.
    localparam logic [0:0] DMV_ZERO_CODE   = 1'b0;
    localparam logic [1:0] DMV_POS_CODE    = 2'b10;
    localparam logic [1:0] DMV_NEG_CODE    = 2'b11;
    localparam logic [2:0] DMV_ZERO_LEN    = 3'd1;
    localparam logic [2:0] DMV_NONZERO_LEN = 3'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } dmv_state_t;

    // Code bits are left-aligned; unused low bits are zero.
    typedef struct packed {
        logic [3:0] bits;
        logic [2:0] len;
    } dmv_code_t;

    function automatic logic is_illegal(input logic [1:0] v);
        return v == DMV_ILLEGAL;
    endfunction

    function automatic dmv_code_t encode_value(input logic [1:0] v);
        dmv_code_t c;
        case (v)
            2'b01: begin
                c.bits = {DMV_POS_CODE, 2'b00};
                c.len  = DMV_NONZERO_LEN;
            end
            2'b11: begin
                c.bits = {DMV_NEG_CODE, 2'b00};
                c.len  = DMV_NONZERO_LEN;
            end
            default: begin
                c.bits = {DMV_ZERO_CODE, 3'b000};
                c.len  = DMV_ZERO_LEN;
            end
        endcase
        return c;
    endfunction

    // The y code is appended directly behind the x code.
    function automatic dmv_code_t encode_pair(input logic [1:0] x, input logic [1:0] y);
        dmv_code_t cx;
        dmv_code_t cy;
        dmv_code_t c;
        cx     = encode_value(x);
        cy     = encode_value(y);
        c.bits = cx.bits | (cy.bits >> cx.len);
        c.len  = cx.len + cy.len;
        return c;
    endfunction

endpackage

// File: rtl/put_dmvector_if.sv
// Producer and bitstream-writer connections of the dmvector serializer.
//
// Handshakes: a pair moves when in_valid && in_ready at a rising edge, and a
// bit moves when bit_valid && bit_ready at a rising edge. A source holds its
// payload and valid stable until the transfer; ready never depends
// combinationally on the matching valid.
interface put_dmvector_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] dmvec_x;
    logic [1:0] dmvec_y;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       done;
    logic       err;
    logic [5:0] bit_count;

    modport slave (
        input  in_valid, dmvec_x, dmvec_y, bit_ready,
        output in_ready, bit_out, bit_valid, done, err, bit_count
    );

    modport master (
        output in_valid, dmvec_x, dmvec_y, bit_ready,
        input  in_ready, bit_out, bit_valid, done, err, bit_count
    );
endinterface

// File: rtl/dmv_fifo.sv
// Synchronous FIFO holding legal dmvector pairs awaiting serialization.
module dmv_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents beyond the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/put_dmvector.sv
// Serializes (dmvec_x, dmvec_y) pairs into variable-length codes, one bit per
// accepted output transfer, with a small FIFO decoupling the producer.
module put_dmvector
    import put_dmvector_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    put_dmvector_if.slave        bus,
    output dmv_state_t           state_dbg
);

    dmv_state_t  state;
    dmv_state_t  state_next;
    logic [3:0]  shreg;
    logic [2:0]  remain;
    logic        done_q;
    logic        err_q;
    logic [5:0]  count_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [3:0]  fifo_rd_data;

    logic        accept;
    logic        pair_bad;
    logic        xfer;
    logic        last_xfer;
    dmv_code_t   load_code;

    // Illegal pairs are still consumed so the producer never stalls on them.
    assign accept    = bus.in_valid && !fifo_full;
    assign pair_bad  = is_illegal(bus.dmvec_x) || is_illegal(bus.dmvec_y);
    assign fifo_push = accept && !pair_bad;
    assign xfer      = (state == ST_SHIFT) && bus.bit_ready;
    assign last_xfer = xfer && (remain == 3'd1);
    assign load_code = encode_pair(fifo_rd_data[3:2], fifo_rd_data[1:0]);

    dmv_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({bus.dmvec_x, bus.dmvec_y}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next state and FIFO pop; the final bit of a code reloads without a bubble.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_xfer) begin
                    if (!fifo_empty) fifo_pop   = 1'b1;
                    else             state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Code shift register and remaining-length counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg  <= '0;
            remain <= '0;
        end else if (fifo_pop) begin
            shreg  <= load_code.bits;
            remain <= load_code.len;
        end else if (xfer) begin
            shreg  <= {shreg[2:0], 1'b0};
            remain <= remain - 3'd1;
        end
    end

    // Status: done pulse, sticky error and wrapping bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= last_xfer;
            if (xfer)              count_q <= count_q + 6'd1;
            if (accept && pair_bad) err_q  <= 1'b1;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.bit_valid = (state == ST_SHIFT);
    assign bus.bit_out   = shreg[3];
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.bit_count = count_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_put_dmvector.sv
// Directed bench for put_dmvector with a bit-level scoreboard model.
module tb_put_dmvector;
    import put_dmvector_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    dmv_state_t state_dbg;
    int         ready_mode = 1;   // 0: low, 1: high, 2: random

    put_dmvector_if bus_if ();

    put_dmvector #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];        // {bit, last_bit_of_pair}
    logic       got_q[$];
    int         got_cyc[$];
    int         cyc      = 0;
    int         done_seen = 0;
    logic [5:0] m_cnt    = '0;
    logic       m_err    = 1'b0;
    logic       m_done   = 1'b0;
    logic       prev_hold = 1'b0;
    logic       prev_bit  = 1'b0;
    logic [1:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: turn an accepted pair into its bit sequence from the value rules.
    task automatic model_accept(input logic [1:0] x, input logic [1:0] y);
        logic b[$];
        int   v[2];
        if (x == 2'b10 || y == 2'b10) begin
            m_err = 1'b1;
        end else begin
            v[0] = int'($signed(x));
            v[1] = int'($signed(y));
            for (int k = 0; k < 2; k++) begin
                if (v[k] == 0) b.push_back(1'b0);
                else begin
                    b.push_back(1'b1);
                    b.push_back(v[k] < 0);
                end
            end
            for (int k = 0; k < b.size(); k++)
                exp_q.push_back({b[k], (k == b.size() - 1)});
        end
    endtask

    function automatic logic [31:0] pack_got();
        logic [31:0] v = '0;
        foreach (got_q[i]) v = {v[30:0], got_q[i]};
        return v;
    endfunction

    // Compare process: outputs are checked every cycle away from the edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            m_cnt     = '0;
            m_err     = 1'b0;
            m_done    = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("done", bus_if.done, m_done);
            check("bit_count", bus_if.bit_count, m_cnt);
            check("err", bus_if.err, m_err);
            if (bus_if.done) done_seen++;
            if (prev_hold) begin
                check("hold_valid", bus_if.bit_valid, 1);
                check("hold_bit", bus_if.bit_out, prev_bit);
            end
            m_done = 1'b0;
            if (bus_if.bit_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit_valid", bus_if.bit_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("bit_out", bus_if.bit_out, e[1]);
                    if (bus_if.bit_ready) begin
                        void'(exp_q.pop_front());
                        m_done = e[0];
                        m_cnt  = m_cnt + 6'd1;
                        got_q.push_back(bus_if.bit_out);
                        got_cyc.push_back(cyc);
                    end
                end
            end
            prev_hold = bus_if.bit_valid && !bus_if.bit_ready;
            prev_bit  = bus_if.bit_out;
            if (bus_if.in_valid && bus_if.in_ready)
                model_accept(bus_if.dmvec_x, bus_if.dmvec_y);
        end
    end

    // Output-side ready driver.
    always begin
        @(posedge clk);
        #3;
        case (ready_mode)
            0:       bus_if.bit_ready = 1'b0;
            1:       bus_if.bit_ready = 1'b1;
            default: bus_if.bit_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst              = 1'b0;
        bus_if.in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push_pair(input logic [1:0] x, input logic [1:0] y);
        int n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.dmvec_x  = x;
        bus_if.dmvec_y  = y;
        @(negedge clk);
        while (!bus_if.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("push_accept", bus_if.in_ready, 1);
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus_if.bit_valid || bus_if.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", (exp_q.size() == 0) && !bus_if.bit_valid, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] t1_bits;
    int         n;

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.dmvec_x   = 2'b00;
        bus_if.dmvec_y   = 2'b00;
        bus_if.bit_ready = 1'b1;
        #2 rst = 1'b0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst_bit_valid", bus_if.bit_valid, 0);
        check("rst_bit_out", bus_if.bit_out, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_err", bus_if.err, 0);
        check("rst_bit_count", bus_if.bit_count, 0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus_if.in_ready, 1);
        @(posedge clk);
        #1;

        // (+1,-1): bits 1,0,1,1 starting two cycles after acceptance.
        t1_bits = 4'b1011;
        push_pair(2'b01, 2'b11);
        @(negedge clk);
        check("t1_latency_idle", bus_if.bit_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", bus_if.bit_valid, 1);
            check("t1_bit", bus_if.bit_out, t1_bits[3-i]);
        end
        @(negedge clk);
        check("t1_end_valid", bus_if.bit_valid, 0);
        check("t1_done", bus_if.done, 1);
        check("t1_count", bus_if.bit_count, 4);
        @(negedge clk);
        check("t1_done_pulse", bus_if.done, 0);
        @(posedge clk);
        #1;

        // (0,0) then (-1,+1) back to back: 0,0,1,1,1,0 without a bubble.
        got_q.delete();
        got_cyc.delete();
        done_seen = 0;
        push_pair(2'b00, 2'b00);
        push_pair(2'b11, 2'b01);
        drain(100);
        check("t2_len", got_q.size(), 6);
        check("t2_bits", pack_got(), 32'b001110);
        check("t2_no_bubble", got_cyc[got_cyc.size()-1] - got_cyc[0], 5);
        check("t2_done_pulses", done_seen, 2);

        // Backpressure: shifter holds one pair, FIFO then takes four more.
        ready_mode = 0;
        @(posedge clk);
        #1;
        push_pair(2'b01, 2'b00);
        n = 0;
        @(negedge clk);
        while (!bus_if.bit_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t3_loaded", bus_if.bit_valid, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.dmvec_x  = (i == 0) ? 2'b11 : (i == 1) ? 2'b00 : (i == 2) ? 2'b01 : 2'b00;
            bus_if.dmvec_y  = (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : (i == 2) ? 2'b01 : 2'b11;
            @(negedge clk);
            check("t3_ready_before_push", bus_if.in_ready, 1);
            @(posedge clk);
            #1;
        end
        bus_if.dmvec_x = 2'b11;
        bus_if.dmvec_y = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_full_ready", bus_if.in_ready, 0);
            check("t3_hold_valid", bus_if.bit_valid, 1);
            check("t3_hold_bit", bus_if.bit_out, 1);
            @(posedge clk);
            #1;
        end
        ready_mode = 1;
        n = 0;
        @(negedge clk);
        while (!bus_if.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t3_fifth_accept", bus_if.in_ready, 1);
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
        drain(200);

        // Illegal pair: no bits, sticky err, later pair still encodes.
        got_q.delete();
        push_pair(2'b10, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_bits", bus_if.bit_valid, 0);
        end
        check("t4_err", bus_if.err, 1);
        @(posedge clk);
        #1;
        push_pair(2'b01, 2'b00);
        drain(100);
        check("t4_len", got_q.size(), 3);
        check("t4_bits", pack_got(), 32'b100);
        check("t4_err_sticky", bus_if.err, 1);

        // Reset after two of four bits.
        reset_dut();
        check("t5_err_cleared", bus_if.err, 0);
        @(posedge clk);
        #1;
        push_pair(2'b01, 2'b11);
        n = 0;
        @(negedge clk);
        while (bus_if.bit_count != 6'd2 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_two_bits", bus_if.bit_count, 2);
        #2 rst = 1'b0;
        #1;
        check("t5_async_valid", bus_if.bit_valid, 0);
        check("t5_async_bit", bus_if.bit_out, 0);
        check("t5_async_done", bus_if.done, 0);
        check("t5_async_count", bus_if.bit_count, 0);
        check("t5_async_state", state_dbg, ST_IDLE);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_done", bus_if.done, 0);
            check("t5_discarded", bus_if.bit_valid, 0);
        end
        @(posedge clk);
        #1;

        // 65 transfers under random backpressure: counter wraps to 1.
        got_q.delete();
        ready_mode = 2;
        for (int i = 0; i < 31; i++) push_pair(2'b00, 2'b00);
        push_pair(2'b01, 2'b00);
        drain(3000);
        check("t6_transfers", got_q.size(), 65);
        check("t6_wrap", bus_if.bit_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/put_dmvector.md
PUT_DMVECTOR -- requirements
Module: put_dmvector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered dmvector pairs (power of two, >=2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  producer presents a dmvector pair.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 dmvec_x  input  2  signed horizontal dmvector, legal values -1, 0, +1.
REQ-007 dmvec_y  input  2  signed vertical dmvector, legal values -1, 0, +1.
REQ-008 bit_out  output  1  current serialized code bit.
REQ-009 bit_valid  output  1  bit_out holds a valid bit.
REQ-010 bit_ready  input  1  downstream bitstream writer accepts bit_out.
REQ-011 done  output  1  one-cycle pulse after the last bit of a pair is accepted.
REQ-012 err  output  1  sticky flag: an illegal value (-2, encoding 2'b10) was presented.
REQ-013 bit_count  output  6  running count of accepted bits, modulo 64.

Function
REQ-014 Encoding per value: 0 -> "0" (1 bit); +1 -> "10"; -1 -> "11" (2 bits, MSB first).
REQ-015 Each pair emits the dmvec_x code followed by the dmvec_y code; pair length is 2 to 4 bits.
REQ-016 Input handshake: a pair is accepted on any cycle with in_valid && in_ready.
REQ-017 in_ready = FIFO not full, registered-state derived; no combinational path from bit_ready.
REQ-018 A pair containing any illegal value is consumed, not stored, emits no bits, and sets err.
REQ-019 Output handshake: a bit transfers on any cycle with bit_valid && bit_ready; bit_out and bit_valid remain stable while bit_ready is low.
REQ-020 FSM states: IDLE (no code loaded, bit_valid=0) and SHIFT (4-bit shift register plus 3-bit remaining-length counter loaded, bit_valid=1).
REQ-021 IDLE -> SHIFT on the cycle after the FIFO becomes non-empty; the FIFO pops on the load.
REQ-022 In SHIFT, each transfer shifts left by one and decrements the remaining length.
REQ-023 On transfer of the final bit: when the FIFO is non-empty, load the next pair in the same cycle and stay in SHIFT with no bubble; otherwise go to IDLE.
REQ-024 done asserts in the cycle after each final-bit transfer and lasts exactly one cycle.
REQ-025 bit_count increments by one per transfer and wraps 63 -> 0.
REQ-026 Latency: the first bit is valid 2 cycles after an accepted pair into an empty, idle block.
REQ-027 Simultaneous push and pop: the FIFO pops in SHIFT and accepts a push in the same cycle, so occupancy is unchanged.
REQ-028 Full FIFO: in_ready=0; in_valid is ignored.

Reset
REQ-029 Assertion (rst=0), asynchronous: state=IDLE, FIFO empty, shift register=0, in_ready=1 after release, bit_valid=0, bit_out=0, done=0, err=0, bit_count=0.
REQ-030 Reset mid-pair discards the partially emitted code and all buffered pairs; no done pulse.
REQ-031 err clears only on reset.

Structure
REQ-032 A shared package holds the code constants (DMV_ZERO_CODE, DMV_POS_CODE, DMV_NEG_CODE, code lengths) and the FSM state typedef.
REQ-033 Buffering is a sub-module dmv_fifo: synchronous FIFO, width 4, depth FIFO_DEPTH, with full/empty outputs and the same clk/rst.

Verification
REQ-034 Pair (+1,-1), bit_ready=1 -> bits 1,0,1,1 on consecutive cycles; done one cycle later; bit_count=4.
REQ-035 Pair (0,0) then (-1,+1) back-to-back, bit_ready=1 -> bits 0,0,1,1,1,0 with no bubble; two done pulses.
REQ-036 Five pairs pushed while bit_ready=0 -> in_ready falls after the 4th push (depth 4); bit_valid held with a stable bit_out.
REQ-037 Pair (2'b10,0) -> no bits emitted; err=1 and it stays set; a following legal pair still encodes correctly.
REQ-038 Reset asserted after 2 of 4 bits -> all outputs reset asynchronously; no done; bit_count=0.
REQ-039 Sixty-five single-bit transfers -> bit_count wraps to 1.
